// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the hazard detection unit.
//   - default widths / multiply latency
//   - multiply-stall FSM state encoding
package hazard_detection_unit_pkg;

  localparam int REG_ADDR_LEN_DEF = 5;
  localparam int MUL_LATENCY_DEF  = 4;
  localparam int CNT_LEN_DEF      = 16;

  // Down-counter width; holds MUL_LATENCY-2 for latencies up to 15.
  localparam int MUL_CNT_W = 4;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_detection_unit_mul_stall_fsm.sv
// Multi-cycle multiply sequencer for the EXE stage.
// Holds the pipe while a multiply occupies EXE for MUL_LATENCY cycles.
//   clk, rst    : clock, async active-high reset
//   exe_is_mul  : EXE-stage instruction is a multiply
//   exe_stall   : hold ID/EXE, bubble into EXE/MEM (forced 0 in reset)
//   mul_busy    : FSM is in BUSY
//
// state   | meaning
// --------+-------------------------------------------------------------
// HZ_IDLE | no multiply in progress; a multiply arriving here stalls at once
// HZ_BUSY | multiply in progress; stalls while cnt != 0, leaves EXE at cnt==0
module mul_stall_fsm
  import hazard_detection_unit_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic exe_is_mul,
  output logic exe_stall,
  output logic mul_busy
);

  localparam bit MUL_STALLS = (MUL_LATENCY > 1);
  localparam logic [MUL_CNT_W-1:0] CNT_START =
    MUL_CNT_W'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);

  hz_state_e             state, state_nxt;
  logic [MUL_CNT_W-1:0]  cnt, cnt_nxt;
  logic                  stall_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    if (state == HZ_IDLE) begin
      // The first multiply cycle is spent here, so BUSY counts L-2 more.
      if (exe_is_mul && MUL_STALLS) begin
        stall_raw = 1'b1;
        state_nxt = HZ_BUSY;
        cnt_nxt   = CNT_START;
      end
    end else begin
      if (cnt != '0) begin
        stall_raw = 1'b1;
        cnt_nxt   = cnt - 1'b1;
      end else begin
        state_nxt = HZ_IDLE;
      end
    end
  end

  // exe_is_mul may still be high during reset; keep the stall quiet.
  assign exe_stall = stall_raw & ~rst;
  assign mul_busy  = (state == HZ_BUSY);

endmodule

// File: rtl/hazard_detection_unit.sv
// Hazard detection beside the ID stage.
// Compares ID sources against EXE/MEM destinations, merges the multiply
// stall and counts stalled cycles (saturating) for performance debug.
//   clk, rst                 : clock, async active-high reset
//   src1, src2, two_src      : ID sources; src2 used only when two_src=1
//   forward_en               : forwarding present, only load-use stalls
//   exe_dest/wb_en/mem_r_en  : EXE-stage destination info
//   exe_is_mul               : EXE-stage instruction is a multiply
//   mem_dest/mem_wb_en       : MEM-stage destination info
//   hazard_detected          : freeze PC and IF/ID, bubble from ID
//   exe_stall, mul_busy      : multiply sequencing status
//   stall_cnt                : cycles with hazard_detected=1, saturating
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
  parameter int MUL_LATENCY  = MUL_LATENCY_DEF,
  parameter int CNT_LEN      = CNT_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] src1,
  input  logic [REG_ADDR_LEN-1:0] src2,
  input  logic                    two_src,
  input  logic                    forward_en,
  input  logic [REG_ADDR_LEN-1:0] exe_dest,
  input  logic                    exe_wb_en,
  input  logic                    exe_mem_r_en,
  input  logic                    exe_is_mul,
  input  logic [REG_ADDR_LEN-1:0] mem_dest,
  input  logic                    mem_wb_en,
  output logic                    hazard_detected,
  output logic                    exe_stall,
  output logic                    mul_busy,
  output logic [CNT_LEN-1:0]      stall_cnt
);

  // Register 0 is hard-wired zero and never creates a dependency.
  function automatic logic reg_hit(input logic [REG_ADDR_LEN-1:0] s,
                                   input logic [REG_ADDR_LEN-1:0] d,
                                   input logic                    en);
    return en && (s == d) && (s != '0);
  endfunction

  logic exe_en;
  logic exe_hz;
  logic mem_hz;
  logic data_hz;

  always_comb begin
    // With forwarding only a load in EXE is too late to forward.
    exe_en  = forward_en ? (exe_wb_en & exe_mem_r_en) : exe_wb_en;
    exe_hz  = reg_hit(src1, exe_dest, exe_en) |
              (two_src & reg_hit(src2, exe_dest, exe_en));
    mem_hz  = reg_hit(src1, mem_dest, mem_wb_en) |
              (two_src & reg_hit(src2, mem_dest, mem_wb_en));
    data_hz = exe_hz | (~forward_en & mem_hz);
  end

  mul_stall_fsm #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_stall_fsm (
    .clk        (clk),
    .rst        (rst),
    .exe_is_mul (exe_is_mul),
    .exe_stall  (exe_stall),
    .mul_busy   (mul_busy)
  );

  assign hazard_detected = ~rst & (data_hz | exe_stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard_detected && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
